// File: rtl/rv32i_types.sv
// Shared RV32I types for the hazard unit and forwarding: register/opcode types,
// hazard FSM state, and the opcode operand-use helpers both units decode with.
package rv32i_types;

  localparam int unsigned REG_W = 5;
  localparam int unsigned OPC_W = 7;

  typedef logic [REG_W-1:0] rv32i_reg;

  typedef enum logic [OPC_W-1:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    KILL  = 2'd2
  } hazard_state_t;

  // Only U/J-type formats leave the rs1 field unused
  function automatic logic uses_rs1(input rv32i_opcode op);
    return !((op == op_lui) || (op == op_auipc) || (op == op_jal));
  endfunction

  function automatic logic uses_rs2(input rv32i_opcode op);
    return (op == op_reg) || (op == op_br) || (op == op_store);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit bundle: hazard sources in, stage enables/flushes and
// performance counters out. The slave modport is the hazard controller.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
) ();
  import rv32i_types::*;

  rv32i_reg    id_rs1;
  rv32i_reg    id_rs2;
  rv32i_opcode id_opcode;
  rv32i_reg    id_ex_rd;
  logic        id_ex_mem_read;
  logic        ex_redirect;
  logic        imem_req;
  logic        imem_resp;
  logic        dmem_req;
  logic        dmem_resp;

  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_en;
  logic        ex_mem_en;
  logic        mem_wb_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        fetch_kill;

  logic [CNT_W-1:0] lu_stall_cnt;
  logic [CNT_W-1:0] dmem_stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_opcode, id_ex_rd, id_ex_mem_read, ex_redirect,
           imem_req, imem_resp, dmem_req, dmem_resp,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, fetch_kill,
           lu_stall_cnt, dmem_stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_opcode, id_ex_rd, id_ex_mem_read, ex_redirect,
           imem_req, imem_resp, dmem_req, dmem_resp,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, fetch_kill,
           lu_stall_cnt, dmem_stall_cnt, flush_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Event counter that increments once per cycle of i_inc and sticks at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: dmem stall, EX redirect (with in-flight
// fetch kill), imem stall and load-use bubble. Counters built only with HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import rv32i_types::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  hazard_state_t r_state;
  hazard_state_t w_state_nxt;

  logic w_dmem_stall;
  logic w_imem_stall;
  logic w_load_use;
  logic w_redir_sel;
  logic w_lu_sel;

  logic w_pc_en;
  logic w_if_id_en;
  logic w_id_ex_en;
  logic w_ex_mem_en;
  logic w_mem_wb_en;
  logic w_if_id_flush;
  logic w_id_ex_flush;
  logic w_fetch_kill;

  assign w_dmem_stall = hz.dmem_req & ~hz.dmem_resp;
  assign w_imem_stall = hz.imem_req & ~hz.imem_resp;

  assign w_load_use = hz.id_ex_mem_read && (hz.id_ex_rd != '0) &&
                      ((uses_rs1(hz.id_opcode) && (hz.id_rs1 == hz.id_ex_rd)) ||
                       (uses_rs2(hz.id_opcode) && (hz.id_rs2 == hz.id_ex_rd)));

  // Redirects are only accepted from RUN; in DWAIT they wait for the next cycle
  assign w_redir_sel = (r_state == RUN) & ~w_dmem_stall & hz.ex_redirect;
  assign w_lu_sel    = ~w_dmem_stall & ~w_imem_stall & w_load_use &
                       (((r_state == RUN) & ~hz.ex_redirect) | (r_state == DWAIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_pc_en       = 1'b1;
    w_if_id_en    = 1'b1;
    w_id_ex_en    = 1'b1;
    w_ex_mem_en   = 1'b1;
    w_mem_wb_en   = 1'b1;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    w_fetch_kill  = 1'b0;
    w_state_nxt   = r_state;

    if (!rst) begin
      w_pc_en       = 1'b0;
      w_if_id_en    = 1'b0;
      w_id_ex_en    = 1'b0;
      w_ex_mem_en   = 1'b0;
      w_mem_wb_en   = 1'b0;
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
      w_state_nxt   = RUN;
    end else begin
      case (r_state)
        RUN: begin
          if (w_dmem_stall) begin
            {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = 5'b00000;
            w_state_nxt = DWAIT;
          end else if (w_redir_sel) begin
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
            if (w_imem_stall) begin
              w_state_nxt = KILL;
            end
          end else if (w_imem_stall) begin
            w_pc_en       = 1'b0;
            w_if_id_flush = 1'b1;
          end else if (w_lu_sel) begin
            w_pc_en       = 1'b0;
            w_if_id_en    = 1'b0;
            w_id_ex_flush = 1'b1;
          end
        end

        DWAIT: begin
          if (w_dmem_stall) begin
            {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = 5'b00000;
          end else begin
            w_state_nxt = RUN;
            if (w_imem_stall) begin
              w_pc_en       = 1'b0;
              w_if_id_flush = 1'b1;
            end else if (w_lu_sel) begin
              w_pc_en       = 1'b0;
              w_if_id_en    = 1'b0;
              w_id_ex_flush = 1'b1;
            end
          end
        end

        // Wrong-path fetch still outstanding: discard it and hold the redirected PC
        KILL: begin
          w_fetch_kill = 1'b1;
          if (w_dmem_stall) begin
            {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = 5'b00000;
            if (hz.imem_resp) begin
              w_state_nxt = DWAIT;
            end
          end else begin
            w_pc_en       = hz.imem_resp;
            w_if_id_flush = 1'b1;
            if (hz.imem_resp) begin
              w_state_nxt = RUN;
            end
          end
        end

        default: begin
          w_state_nxt = RUN;
        end
      endcase
    end
  end

  assign hz.pc_en       = w_pc_en;
  assign hz.if_id_en    = w_if_id_en;
  assign hz.id_ex_en    = w_id_ex_en;
  assign hz.ex_mem_en   = w_ex_mem_en;
  assign hz.mem_wb_en   = w_mem_wb_en;
  assign hz.if_id_flush = w_if_id_flush;
  assign hz.id_ex_flush = w_id_ex_flush;
  assign hz.fetch_kill  = w_fetch_kill;

`ifdef HAZARD_PERF_CNT_EN
  sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_inc   (w_lu_sel),
    .o_count (hz.lu_stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_dmem_cnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_inc   (w_dmem_stall),
    .o_count (hz.dmem_stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_inc   (w_redir_sel),
    .o_count (hz.flush_cnt)
  );
`else
  assign hz.lu_stall_cnt   = CNT_W'(0);
  assign hz.dmem_stall_cnt = CNT_W'(0);
  assign hz.flush_cnt      = CNT_W'(0);
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; counter expectations follow HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl;
  import rv32i_types::*;

  localparam int unsigned CW = 4;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, fetch_kill}
  localparam logic [7:0] O_RST    = 8'b00000_110;
  localparam logic [7:0] O_RUN    = 8'b11111_000;
  localparam logic [7:0] O_DSTALL = 8'b00000_000;
  localparam logic [7:0] O_LU     = 8'b00111_010;
  localparam logic [7:0] O_REDIR  = 8'b11111_110;
  localparam logic [7:0] O_ISTALL = 8'b01111_100;
  localparam logic [7:0] O_KWAIT  = 8'b01111_101;
  localparam logic [7:0] O_KRESP  = 8'b11111_101;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  hazard_ctrl_if #(.CNT_W(CW)) hz ();

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] w_out;
  assign w_out = {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en,
                  hz.if_id_flush, hz.id_ex_flush, hz.fetch_kill};

  task automatic chk_out(input string tag, input logic [7:0] exp);
    n_checks++;
    assert (w_out === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, w_out, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [CW-1:0] obs, input int n);
    logic [CW-1:0] e;
    e = PERF ? CW'(n) : '0;
    n_checks++;
    assert (obs === e) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
    end
  endtask

  task automatic chk_counts(input string tag, input int lu, input int dm, input int fl);
    chk_cnt({tag, "_lu"}, hz.lu_stall_cnt, lu);
    chk_cnt({tag, "_dm"}, hz.dmem_stall_cnt, dm);
    chk_cnt({tag, "_fl"}, hz.flush_cnt, fl);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    hz.id_rs1         = '0;
    hz.id_rs2         = '0;
    hz.id_opcode      = op_imm;
    hz.id_ex_rd       = '0;
    hz.id_ex_mem_read = 1'b0;
    hz.ex_redirect    = 1'b0;
    hz.imem_req       = 1'b0;
    hz.imem_resp      = 1'b0;
    hz.dmem_req       = 1'b0;
    hz.dmem_resp      = 1'b0;
  endtask

  task automatic set_lu(input rv32i_opcode op, input rv32i_reg rd,
                        input rv32i_reg rs1, input rv32i_reg rs2);
    hz.id_ex_mem_read = 1'b1;
    hz.id_ex_rd       = rd;
    hz.id_opcode      = op;
    hz.id_rs1         = rs1;
    hz.id_rs2         = rs2;
  endtask

  initial begin
    rst = 1'b0;
    clear();
    #2;
    chk_out("reset_out", O_RST);
    chk_counts("reset", 0, 0, 0);
    cyc(); cyc();
    rst = 1'b1; #1;
    chk_out("idle", O_RUN);

    // load-use on rs1 and on a store's rs2
    cyc(); set_lu(op_reg, 5'd5, 5'd5, 5'd1); #1;
    chk_out("lu_rs1", O_LU);
    cyc(); hz.id_ex_mem_read = 1'b0; hz.id_ex_rd = '0; #1;
    chk_out("lu_bubble_done", O_RUN);
    chk_cnt("lu_cnt1", hz.lu_stall_cnt, 1);
    cyc(); set_lu(op_store, 5'd5, 5'd2, 5'd5); #1;
    chk_out("lu_store_rs2", O_LU);

    // no stall: x0 destination, lui (rs1 unused), op_imm (rs2 unused)
    cyc(); set_lu(op_reg, 5'd0, 5'd0, 5'd1); #1;
    chk_out("lu_x0", O_RUN);
    chk_cnt("lu_cnt2", hz.lu_stall_cnt, 2);
    cyc(); set_lu(op_lui, 5'd5, 5'd5, 5'd5); #1;
    chk_out("lu_lui", O_RUN);
    cyc(); set_lu(op_imm, 5'd5, 5'd1, 5'd5); #1;
    chk_out("lu_imm_rs2", O_RUN);
    cyc(); clear(); #1;
    chk_counts("after_lu", 2, 0, 0);

    // dmem stall for 4 cycles
    hz.dmem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; chk_out("dstall", O_DSTALL);
      cyc();
    end
    hz.dmem_resp = 1'b1; #1;
    chk_out("dresp", O_RUN);
    chk_cnt("dm_cnt4", hz.dmem_stall_cnt, 4);
    cyc(); clear(); #1;
    chk_out("dpost", O_RUN);

    // imem stall, then redirect during a 3-cycle imem wait
    cyc(); hz.imem_req = 1'b1; #1;
    chk_out("istall", O_ISTALL);
    cyc(); hz.ex_redirect = 1'b1; #1;
    chk_out("redir_iwait", O_REDIR);
    cyc(); hz.ex_redirect = 1'b0; #1;
    chk_out("kill_wait1", O_KWAIT);
    chk_cnt("fl_cnt1", hz.flush_cnt, 1);
    cyc(); #1;
    chk_out("kill_wait2", O_KWAIT);
    cyc(); hz.imem_resp = 1'b1; #1;
    chk_out("kill_resp", O_KRESP);
    cyc(); clear(); #1;
    chk_out("kill_done", O_RUN);
    chk_counts("after_kill", 2, 4, 1);

    // load-use coinciding with redirect
    cyc(); set_lu(op_reg, 5'd5, 5'd5, 5'd1); hz.ex_redirect = 1'b1; #1;
    chk_out("lu_redir", O_REDIR);
    cyc(); clear(); #1;
    chk_out("lu_redir_post", O_RUN);
    chk_counts("after_lu_redir", 2, 4, 2);

    // dmem stall beats redirect; redirect held through DWAIT
    cyc(); hz.dmem_req = 1'b1; hz.ex_redirect = 1'b1; #1;
    chk_out("dm_over_redir", O_DSTALL);
    cyc(); #1;
    chk_out("dwait_redir", O_DSTALL);
    cyc(); hz.dmem_resp = 1'b1; #1;
    chk_out("dresp_redir_held", O_RUN);
    cyc(); hz.dmem_req = 1'b0; hz.dmem_resp = 1'b0; #1;
    chk_out("redir_after_dwait", O_REDIR);
    cyc(); clear(); #1;
    chk_out("post_held_redir", O_RUN);
    chk_counts("after_held", 2, 6, 3);

    // imem stall beats load-use
    cyc(); hz.imem_req = 1'b1; set_lu(op_reg, 5'd5, 5'd5, 5'd1); #1;
    chk_out("istall_over_lu", O_ISTALL);
    cyc(); clear(); #1;
    chk_out("istall_lu_post", O_RUN);
    chk_cnt("lu_cnt_unchanged", hz.lu_stall_cnt, 2);

    // reset mid-DWAIT; release with a redirect to show RUN behaviour
    cyc(); hz.dmem_req = 1'b1; #1;
    chk_out("pre_rst_dstall", O_DSTALL);
    cyc(); rst = 1'b0; #1;
    chk_out("rst_dwait", O_RST);
    chk_counts("rst_dwait", 0, 0, 0);
    cyc(); hz.dmem_req = 1'b0; hz.ex_redirect = 1'b1; rst = 1'b1; #1;
    chk_out("rst_dwait_rel", O_REDIR);
    chk_counts("rst_dwait_rel", 0, 0, 0);
    cyc(); clear(); #1;
    chk_out("rst_dwait_idle", O_RUN);
    chk_cnt("fl_after_rst", hz.flush_cnt, 1);

    // reset mid-KILL
    cyc(); hz.imem_req = 1'b1; hz.ex_redirect = 1'b1; #1;
    chk_out("pre_kill", O_REDIR);
    cyc(); hz.ex_redirect = 1'b0; #1;
    chk_out("in_kill", O_KWAIT);
    cyc(); rst = 1'b0; #1;
    chk_out("rst_kill", O_RST);
    cyc(); hz.imem_req = 1'b0; rst = 1'b1; #1;
    chk_out("rst_kill_rel", O_RUN);
    chk_counts("rst_kill_rel", 0, 0, 0);

    // dmem stall counter saturation at 4 bits
    cyc(); hz.dmem_req = 1'b1;
    repeat (20) cyc();
    hz.dmem_req = 1'b0; #1;
    chk_out("sat_exit", O_RUN);
    chk_cnt("dm_saturate", hz.dmem_stall_cnt, 15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of each performance counter.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports id_rs1, id_rs2  input  rv32i_reg  source registers of the instruction in IF/ID.
REQ-005 SHALL have port id_opcode  input  rv32i_opcode  opcode of the instruction in IF/ID.
REQ-006 SHALL have ports id_ex_rd  input  rv32i_reg, and id_ex_mem_read  input  1  (ID/EX holds a load).
REQ-007 SHALL have port ex_redirect  input  1  branch taken or jump resolved in EX.
REQ-008 SHALL have ports imem_req, imem_resp, dmem_req, dmem_resp  input  1  each  memory request/response handshakes.
REQ-009 SHALL have outputs pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  1 each  pipeline register load enables.
REQ-010 SHALL have outputs if_id_flush, id_ex_flush, fetch_kill  1 each  bubble-insert and in-flight fetch discard.
REQ-011 SHALL have outputs lu_stall_cnt, dmem_stall_cnt, flush_cnt  CNT_W each  performance counters.

Function
REQ-012 SHALL decode uses_rs1 = opcode not lui/auipc/jal and uses_rs2 = opcode reg/br/store, matching the forwarding rule.
REQ-013 SHALL flag load-use when id_ex_mem_read, id_ex_rd != 0, and id_ex_rd matches a used rs1 or rs2 of id_opcode.
REQ-014 SHALL implement states RUN, DWAIT, KILL; outputs are combinational from state and inputs.
REQ-015 Priority SHALL be: dmem stall > redirect > imem stall > load-use.
REQ-016 Dmem stall (dmem_req & !dmem_resp): all five enables 0, no flushes; state DWAIT until dmem_resp, then RUN on the same edge.
REQ-017 Redirect in RUN with no imem stall: all enables 1, if_id_flush=1, id_ex_flush=1 for exactly that cycle.
REQ-018 Redirect while imem_req & !imem_resp: flushes as REQ-017, pc_en=1; next state KILL.
REQ-019 In KILL: fetch_kill=1 and pc_en=0 until imem_resp; on the imem_resp cycle if_id_flush=1, pc_en=1, next state RUN.
REQ-020 Imem stall (no redirect): pc_en=0, if_id_flush=1, all downstream enables 1.
REQ-021 Load-use: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=mem_wb_en=1; exactly one bubble per hazard.
REQ-022 Redirect coinciding with load-use SHALL take redirect behaviour only; no stall is inserted.
REQ-023 Redirect arriving during DWAIT SHALL be held off; ex_redirect is re-evaluated on the cycle after dmem_resp.
REQ-024 No hazard: all enables 1, all flushes 0, fetch_kill 0.
REQ-025 Counters SHALL increment once per cycle of their condition (load-use, dmem stall, redirect) and saturate at all-ones.

Reset
REQ-026 While rst=0: state RUN, all counters 0, all enables 0, if_id_flush=id_ex_flush=1, fetch_kill=0.
REQ-027 Reset asserted mid-DWAIT or mid-KILL SHALL abandon the state immediately; the first cycle after release behaves as RUN.

Configuration
REQ-028 With HAZARD_PERF_CNT_EN defined: counters as REQ-025; without it: the counter ports remain and are tied to 0, and no counter flops are built.

Structure
REQ-029 SHALL place the state enum (hazard_state_t) and opcode-use helper functions in rv32i_types; the forwarding unit SHALL reuse the helpers.
REQ-030 SHALL instantiate one sub-module, sat_counter (parameter CNT_W), three times under the macro; no other sub-modules.

Verification
REQ-031 lw x5 in ID/EX, add x6,x5,x1 in IF/ID -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1; lu_stall_cnt=1.
REQ-032 lw x0 in ID/EX, add x6,x0,x1 -> no stall; lui x5 after lw x5 -> no stall (rs1 unused).
REQ-033 dmem_req=1, dmem_resp low for 4 cycles -> all enables 0 for 4 cycles, then all enables 1; dmem_stall_cnt=4.
REQ-034 ex_redirect during imem wait of 3 cycles -> flushes on the redirect cycle, fetch_kill high until imem_resp, if_id_flush on resp; flush_cnt=1.
REQ-035 Load-use and ex_redirect in the same cycle -> both flushes, pc_en=1, lu_stall_cnt unchanged.
REQ-036 rst pulled low during DWAIT -> reset outputs immediately; after release with no hazards, all enables 1 and counters 0.
